// File: rtl/cdr_pkg.sv
// cdr_pkg: shared widths, period-length limits and the clamp helper for the CDR sampling-phase logic
package cdr_pkg;
   localparam int CNT_W     = 6;
   localparam int NB_P_INIT = 25;
   localparam int NB_P_MIN  = 8;
   localparam int NB_P_LO   = 23;
   localparam int NB_P_HI   = 27;
   typedef logic [CNT_W-1:0] nb_p_t;
   function automatic nb_p_t clamp_nb_p(input nb_p_t v);
      return (v < nb_p_t'(NB_P_MIN)) ? nb_p_t'(NB_P_MIN) : v;
   endfunction
endpackage

// File: rtl/cdr_mod_counter.sv
// cdr_mod_counter: wrap counter 0..i_last advancing when i_en is high
// ports: i_clk/i_rst clock and sync active-high reset, i_en advance, i_last terminal value, o_cnt count
module cdr_mod_counter #(
   parameter int W = 6
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_en,
   input  logic [W-1:0] i_last,
   output logic [W-1:0] o_cnt
);
   always_ff @(posedge i_clk)
      if (i_rst) o_cnt <= '0;
      else if (i_en) o_cnt <= (o_cnt == i_last) ? '0 : o_cnt + 1'b1;
endmodule

// File: rtl/cdr_counter.sv
// cdr_counter: CDR sampling-phase counter producing early/middle/late, period and freq-sync strobes
// ports: i_clk/i_rst clock and sync active-high reset, i_nb_P requested period length,
//        o_en_d/o_en_m/o_en_f early/middle/late strobes, o_en end-of-period, o_en_freq_synch every SYNC_DIV periods
module cdr_counter
   import cdr_pkg::*;
#(
   parameter int EL_OFFSET = 2,
   parameter int SYNC_DIV  = 16
) (
   input  logic  i_clk,
   input  logic  i_rst,
   input  nb_p_t i_nb_P,
   output logic  o_en_d,
   output logic  o_en_m,
   output logic  o_en_f,
   output logic  o_en,
   output logic  o_en_freq_synch
);
   localparam int PW = (SYNC_DIV > 1) ? $clog2(SYNC_DIV) : 1;
   localparam logic [PW-1:0] PLAST = PW'(SYNC_DIV - 1);
   localparam nb_p_t EL = nb_p_t'(EL_OFFSET);
   nb_p_t cnt, p_act, mid, last;
   logic [PW-1:0] per_cnt;
   logic wrap;
   assign mid  = p_act >> 1;
   assign last = p_act - nb_p_t'(1);
   assign wrap = cnt == last;
   cdr_mod_counter #(.W(CNT_W)) u_phase (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (1'b1),
      .i_last(last),
      .o_cnt (cnt)
   );
   cdr_mod_counter #(.W(PW)) u_period (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (wrap),
      .i_last(PLAST),
      .o_cnt (per_cnt)
   );
   // the requested length only takes effect at the wrap, so a period is never cut short or stretched
   always_ff @(posedge i_clk)
      if (i_rst) p_act <= nb_p_t'(NB_P_INIT);
      else if (wrap) p_act <= clamp_nb_p(i_nb_P);
   // gated by i_rst so a mid-period reset silences the strobes in the very cycle it is raised
   assign o_en_d          = ~i_rst & (cnt == mid - EL);
   assign o_en_m          = ~i_rst & (cnt == mid);
   assign o_en_f          = ~i_rst & (cnt == mid + EL);
   assign o_en            = ~i_rst & wrap;
   assign o_en_freq_synch = ~i_rst & wrap & (per_cnt == PLAST);
endmodule

// File: tb/tb_cdr_counter.sv
// tb_cdr_counter: directed checks of strobe timing, reload, clamping, reset and freq-sync spacing
module tb_cdr_counter;
   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   logic [5:0] i_nb_P = 6'd25;
   logic o_en_d, o_en_m, o_en_f, o_en, o_en_freq_synch;
   logic [4:0] outs;
   int n_chk = 0;
   int n_err = 0;
   int pidx = 0;
   int lens[$];
   int req[$];
   cdr_counter dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_nb_P         (i_nb_P),
      .o_en_d         (o_en_d),
      .o_en_m         (o_en_m),
      .o_en_f         (o_en_f),
      .o_en           (o_en),
      .o_en_freq_synch(o_en_freq_synch)
   );
   always #10 i_clk = ~i_clk;
   assign outs = {o_en_d, o_en_m, o_en_f, o_en, o_en_freq_synch};
   task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got d,m,f,en,fs=%b expected %b", tag, got, exp);
      end
   endtask
   // strobe offsets per period length, worked out by hand: d=mid-2, m=mid, f=mid+2, en=len-1
   function automatic logic [4:0] expv(input int len, input int o, input bit fs);
      int d, m, f;
      case (len)
         25: begin d = 10; m = 12; f = 14; end
         27: begin d = 11; m = 13; f = 15; end
         23: begin d = 9;  m = 11; f = 13; end
         8:  begin d = 2;  m = 4;  f = 6;  end
         default: begin d = -1; m = -1; f = -1; end
      endcase
      return {o == d, o == m, o == f, o == len - 1, (o == len - 1) && fs};
   endfunction
   task automatic do_reset();
      i_rst = 1'b1;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      #1 check("reset", outs, 5'b0);
      i_rst = 1'b0;
      pidx = 0;
   endtask
   // period k runs lens[k] cycles; req[k] is driven from offset 5 and sets the length of period k+1
   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         for (int o = 0; o < lens[k]; o++) begin
            if (o == 5) i_nb_P = 6'(req[k]);
            #1 check($sformatf("p%0d o%0d", pidx, o), outs, expv(lens[k], o, (pidx % 16) == 15));
            @(negedge i_clk);
         end
         pidx++;
      end
   endtask
   initial begin
      lens = {};
      req = {};
      for (int k = 0; k < 34; k++) begin
         lens.push_back(25);
         req.push_back(25);
      end
      i_nb_P = 6'd25;
      do_reset();
      run(34);
      lens = '{25, 27, 23, 25};
      req  = '{27, 23, 25, 25};
      do_reset();
      run(4);
      i_nb_P = 6'd3;
      lens = '{25, 8, 8, 8};
      req  = '{3, 3, 3, 25};
      do_reset();
      run(4);
      i_nb_P = 6'd25;
      lens = {};
      req = {};
      for (int k = 0; k < 17; k++) begin
         lens.push_back(25);
         req.push_back(25);
      end
      do_reset();
      run(1);
      for (int o = 0; o < 12; o++) begin
         #1 check($sformatf("pre-rst o%0d", o), outs, expv(25, o, 1'b0));
         @(negedge i_clk);
      end
      i_rst = 1'b1;
      #1 check("rst at middle strobe", outs, 5'b0);
      @(negedge i_clk);
      #1 check("rst held", outs, 5'b0);
      @(negedge i_clk);
      i_rst = 1'b0;
      pidx = 0;
      run(17);
      lens = '{25, 23, 27, 23, 27, 23};
      req  = '{23, 27, 23, 27, 23, 25};
      do_reset();
      run(6);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
